// File: rtl/tinyalu_cmd_driver_if.sv
// Command, ALU pin and response signals of the TinyALU command driver.
// slave: the driver (takes commands, drives ALU pins, offers responses).
// master: the system side (issues commands, plays the ALU, takes responses).
interface tinyalu_cmd_driver_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [7:0]  cmd_a;
  logic [7:0]  cmd_b;
  logic [2:0]  cmd_op;

  logic [7:0]  alu_a;
  logic [7:0]  alu_b;
  logic [2:0]  alu_op;
  logic        alu_start;
  logic        alu_reset_n;
  logic        alu_done;
  logic [15:0] alu_result;

  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_result;
  logic [2:0]  rsp_op;
  logic        rsp_timeout;

  modport slave (
    input  cmd_valid, cmd_a, cmd_b, cmd_op,
    output cmd_ready,
    output alu_a, alu_b, alu_op, alu_start, alu_reset_n,
    input  alu_done, alu_result,
    output rsp_valid, rsp_result, rsp_op, rsp_timeout,
    input  rsp_ready
  );

  modport master (
    output cmd_valid, cmd_a, cmd_b, cmd_op,
    input  cmd_ready,
    input  alu_a, alu_b, alu_op, alu_start, alu_reset_n,
    output alu_done, alu_result,
    input  rsp_valid, rsp_result, rsp_op, rsp_timeout,
    output rsp_ready
  );
endinterface

// File: rtl/tinyalu_cmd_driver.sv
// Purpose: buffers ALU commands, drives the TinyALU pin protocol, returns results.
// Latency: pop on the edge after push into an empty FIFO; response 1 edge after done/NOP end/reset end.
// Backpressure: cmd_ready low when FIFO full; response held stable until rsp_ready.
// Optional statistics ports are built when TINYALU_DRV_STATS_EN is defined.

// Generic synchronous FIFO with occupancy count; pointers wrap modulo DEPTH.
module tinyalu_cmd_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int LVL_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_vld,
  output logic             push_rdy,
  input  logic [WIDTH-1:0] push_dat,
  output logic             pop_vld,
  input  logic             pop_rdy,
  output logic [WIDTH-1:0] pop_dat,
  output logic [LVL_W-1:0] level
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [LVL_W-1:0] level_q;
  logic             push_fire;
  logic             pop_fire;

  assign push_rdy  = (level_q != LVL_W'(DEPTH));
  assign pop_vld   = (level_q != '0);
  assign push_fire = push_vld & push_rdy;
  assign pop_fire  = pop_rdy & pop_vld;
  assign pop_dat   = mem_q[rd_ptr_q];
  assign level     = level_q;

  // Pointer and occupancy tracking; simultaneous push and pop keep the level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push_fire) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop_fire)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({push_fire, pop_fire})
        2'b10:   level_q <= level_q + LVL_W'(1);
        2'b01:   level_q <= level_q - LVL_W'(1);
        default: level_q <= level_q;
      endcase
    end
  end

  // Storage needs no reset: the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (push_fire) mem_q[wr_ptr_q] <= push_dat;
  end
endmodule

module tinyalu_cmd_driver #(
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 16
) (
  input  logic                            clk,
  input  logic                            reset_n,
  tinyalu_cmd_driver_if.slave             bus,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_level
`ifdef TINYALU_DRV_STATS_EN
  ,
  output logic [15:0]                     stat_ops,
  output logic [7:0]                      stat_timeouts
`endif
);
  localparam int LVL_W = $clog2(FIFO_DEPTH + 1);
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  localparam logic [2:0] OP_ADD = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_XOR = 3'b011;
  localparam logic [2:0] OP_MUL = 3'b100;
  localparam logic [2:0] OP_RST = 3'b111;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] op;
  } cmd_t;

  typedef enum logic [2:0] {S_IDLE, S_EXEC, S_NOP, S_RST, S_RESP} state_t;

  cmd_t   push_cmd;
  cmd_t   head_cmd;
  logic   fifo_vld;
  logic   fifo_pop;

  state_t          state_q, state_d;
  logic [7:0]      alu_a_q, alu_a_d;
  logic [7:0]      alu_b_q, alu_b_d;
  logic [2:0]      alu_op_q, alu_op_d;
  logic            alu_start_q, alu_start_d;
  logic            alu_reset_n_q, alu_reset_n_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic [15:0]     rsp_result_q, rsp_result_d;
  logic [2:0]      rsp_op_q, rsp_op_d;
  logic            rsp_timeout_q, rsp_timeout_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign push_cmd = '{a: bus.cmd_a, b: bus.cmd_b, op: bus.cmd_op};

  tinyalu_cmd_fifo #(
    .WIDTH ($bits(cmd_t)),
    .DEPTH (FIFO_DEPTH),
    .LVL_W (LVL_W)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (reset_n),
    .push_vld (bus.cmd_valid),
    .push_rdy (bus.cmd_ready),
    .push_dat (push_cmd),
    .pop_vld  (fifo_vld),
    .pop_rdy  (fifo_pop),
    .pop_dat  (head_cmd),
    .level    (fifo_level)
  );

  assign bus.alu_a       = alu_a_q;
  assign bus.alu_b       = alu_b_q;
  assign bus.alu_op      = alu_op_q;
  assign bus.alu_start   = alu_start_q;
  assign bus.alu_reset_n = alu_reset_n_q;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_result  = rsp_result_q;
  assign bus.rsp_op      = rsp_op_q;
  assign bus.rsp_timeout = rsp_timeout_q;

  // State and registered outputs; alu_reset_n rises on the first edge after reset release.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= S_IDLE;
      alu_a_q       <= '0;
      alu_b_q       <= '0;
      alu_op_q      <= '0;
      alu_start_q   <= 1'b0;
      alu_reset_n_q <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_result_q  <= '0;
      rsp_op_q      <= '0;
      rsp_timeout_q <= 1'b0;
      cnt_q         <= '0;
    end else begin
      state_q       <= state_d;
      alu_a_q       <= alu_a_d;
      alu_b_q       <= alu_b_d;
      alu_op_q      <= alu_op_d;
      alu_start_q   <= alu_start_d;
      alu_reset_n_q <= alu_reset_n_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_result_q  <= rsp_result_d;
      rsp_op_q      <= rsp_op_d;
      rsp_timeout_q <= rsp_timeout_d;
      cnt_q         <= cnt_d;
    end
  end

  // Next-state and output decode; alu_reset_n defaults high and is only pulled low in RST.
  always_comb begin
    state_d       = state_q;
    alu_a_d       = alu_a_q;
    alu_b_d       = alu_b_q;
    alu_op_d      = alu_op_q;
    alu_start_d   = alu_start_q;
    alu_reset_n_d = 1'b1;
    rsp_valid_d   = rsp_valid_q;
    rsp_result_d  = rsp_result_q;
    rsp_op_d      = rsp_op_q;
    rsp_timeout_d = rsp_timeout_q;
    cnt_d         = cnt_q;
    fifo_pop      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (fifo_vld) begin
          fifo_pop = 1'b1;
          alu_a_d  = head_cmd.a;
          alu_b_d  = head_cmd.b;
          alu_op_d = head_cmd.op;
          rsp_op_d = head_cmd.op;
          cnt_d    = '0;
          case (head_cmd.op)
            OP_ADD, OP_AND, OP_XOR, OP_MUL: begin
              state_d     = S_EXEC;
              alu_start_d = 1'b1;
            end
            OP_RST: begin
              state_d       = S_RST;
              alu_reset_n_d = 1'b0;
              alu_start_d   = 1'b0;
            end
            default: begin
              // no_op and the two unused codes only pulse start for one cycle
              state_d     = S_NOP;
              alu_start_d = 1'b1;
            end
          endcase
        end
      end
      S_EXEC: begin
        if (bus.alu_done) begin
          alu_start_d   = 1'b0;
          rsp_result_d  = bus.alu_result;
          rsp_timeout_d = 1'b0;
          rsp_valid_d   = 1'b1;
          state_d       = S_RESP;
        end else if (cnt_q == CNT_LAST) begin
          alu_start_d   = 1'b0;
          rsp_result_d  = 16'hFFFF;
          rsp_timeout_d = 1'b1;
          rsp_valid_d   = 1'b1;
          state_d       = S_RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_NOP: begin
        alu_start_d   = 1'b0;
        rsp_result_d  = '0;
        rsp_timeout_d = 1'b0;
        rsp_valid_d   = 1'b1;
        state_d       = S_RESP;
      end
      S_RST: begin
        if (cnt_q == CNT_W'(1)) begin
          rsp_result_d  = '0;
          rsp_timeout_d = 1'b0;
          rsp_valid_d   = 1'b1;
          state_d       = S_RESP;
        end else begin
          alu_reset_n_d = 1'b0;
          cnt_d         = cnt_q + CNT_W'(1);
        end
      end
      S_RESP: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

`ifdef TINYALU_DRV_STATS_EN
  logic        rsp_hs;
  logic        timeout_evt;
  logic [15:0] stat_ops_q;
  logic [7:0]  stat_timeouts_q;

  assign rsp_hs      = (state_q == S_RESP) & bus.rsp_ready;
  assign timeout_evt = (state_q == S_EXEC) & ~bus.alu_done & (cnt_q == CNT_LAST);
  assign stat_ops      = stat_ops_q;
  assign stat_timeouts = stat_timeouts_q;

  // Saturating counters of completed responses and timeouts.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stat_ops_q      <= '0;
      stat_timeouts_q <= '0;
    end else begin
      if (rsp_hs && stat_ops_q != 16'hFFFF)          stat_ops_q      <= stat_ops_q + 16'd1;
      if (timeout_evt && stat_timeouts_q != 8'hFF)   stat_timeouts_q <= stat_timeouts_q + 8'd1;
    end
  end
`endif
endmodule

// File: tb/tb_tinyalu_cmd_driver.sv
// Directed bench for tinyalu_cmd_driver with a behavioural ALU and a response scoreboard.
module tb_tinyalu_cmd_driver;
  localparam int FD = 4;
  localparam int TO = 16;

  typedef struct packed {
    logic [2:0]  op;
    logic [15:0] res;
    logic        to;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n;
  logic [2:0] fifo_level;
`ifdef TINYALU_DRV_STATS_EN
  logic [15:0] stat_ops;
  logic [7:0]  stat_timeouts;
`endif

  tinyalu_cmd_driver_if bus ();

  tinyalu_cmd_driver #(.FIFO_DEPTH(FD), .TIMEOUT(TO)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .bus        (bus),
    .fifo_level (fifo_level)
`ifdef TINYALU_DRV_STATS_EN
    ,
    .stat_ops      (stat_ops),
    .stat_timeouts (stat_timeouts)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;
  int fails  = 0;
  exp_t exp_q[$];
  int rsp_count = 0;
  int lat = 1;
  int acnt = 0;
  int run = 0, last_run = 0;
  int rlow = 0, last_rlow = 0;
  int start_in_rst = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] alu_calc(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      3'b001:  return 16'(a) + 16'(b);
      3'b010:  return {8'h00, a & b};
      3'b011:  return {8'h00, a ^ b};
      3'b100:  return 16'(a) * 16'(b);
      default: return 16'h0000;
    endcase
  endfunction

  function automatic exp_t mk_exp(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op, input int l);
    exp_t e;
    e.op = op;
    e.to = 1'b0;
    e.res = 16'h0000;
    if (op inside {3'b001, 3'b010, 3'b011, 3'b100}) begin
      if (l == 0) begin
        e.res = 16'hFFFF;
        e.to  = 1'b1;
      end else begin
        case (op)
          3'b001: e.res = {8'h00, a} + {8'h00, b};
          3'b010: e.res = {8'h00, a & b};
          3'b011: e.res = {8'h00, a ^ b};
          default: e.res = {8'h00, a} * {8'h00, b};
        endcase
      end
    end
    return e;
  endfunction

  // Behavioural ALU: done pulses when start has been high for 'lat' cycles (lat=0: never).
  always @(posedge clk) begin
    #1;
    if (bus.alu_start) acnt++; else acnt = 0;
    if (bus.alu_start && lat != 0 && acnt == lat) begin
      bus.alu_done   = 1'b1;
      bus.alu_result = alu_calc(bus.alu_op, bus.alu_a, bus.alu_b);
    end else begin
      bus.alu_done   = 1'b0;
      bus.alu_result = 16'hDEAD;
    end
  end

  // Pulse-width monitors and response scoreboard.
  always @(negedge clk) begin
    if (bus.alu_start) run++;
    else if (run != 0) begin last_run = run; run = 0; end
    if (!reset_n) rlow = 0;
    else if (!bus.alu_reset_n) rlow++;
    else if (rlow != 0) begin last_rlow = rlow; rlow = 0; end
    if (reset_n && !bus.alu_reset_n && bus.alu_start) start_in_rst++;
    if (reset_n && bus.rsp_valid && bus.rsp_ready) begin
      if (exp_q.size() == 0) chk("rsp_extra", 32'(exp_q.size()), 32'd1);
      else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("rsp_op",      32'(bus.rsp_op),      32'(e.op));
        chk("rsp_result",  32'(bus.rsp_result),  32'(e.res));
        chk("rsp_timeout", 32'(bus.rsp_timeout), 32'(e.to));
      end
      rsp_count++;
    end
  end

  task automatic push(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
    int n = 0;
    bus.cmd_a = a;
    bus.cmd_b = b;
    bus.cmd_op = op;
    bus.cmd_valid = 1'b1;
    @(negedge clk);
    while (!bus.cmd_ready && n < 100) begin @(negedge clk); n++; end
    chk("push_accept", 32'(bus.cmd_ready), 32'd1);
    exp_q.push_back(mk_exp(a, b, op, lat));
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int target);
    int n = 0;
    while (rsp_count < target && n < 200) begin @(negedge clk); n++; end
    chk("rsp_wait", 32'(rsp_count), 32'(target));
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal;
  end

  initial begin
    int vcnt;
    reset_n = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_a = 8'h00;
    bus.cmd_b = 8'h00;
    bus.cmd_op = 3'b000;
    bus.rsp_ready = 1'b0;
    bus.alu_done = 1'b0;
    bus.alu_result = 16'h0000;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_alu_start",   32'(bus.alu_start),   32'd0);
    chk("rst_alu_reset_n", 32'(bus.alu_reset_n), 32'd0);
    chk("rst_rsp_valid",   32'(bus.rsp_valid),   32'd0);
    chk("rst_cmd_ready",   32'(bus.cmd_ready),   32'd1);
    chk("rst_fifo_level",  32'(fifo_level),      32'd0);
    @(posedge clk); #1 reset_n = 1'b1;
    @(negedge clk);
    chk("rel_alu_reset_n_low", 32'(bus.alu_reset_n), 32'd0);
    @(negedge clk);
    chk("rel_alu_reset_n_high", 32'(bus.alu_reset_n), 32'd1);

    // add 05+03, done one cycle after start
    @(posedge clk); #1;
    bus.rsp_ready = 1'b1;
    lat = 1;
    push(8'h05, 8'h03, 3'b001);
    @(negedge clk);
    chk("add_level_after_push", 32'(fifo_level), 32'd1);
    chk("add_start_before_pop", 32'(bus.alu_start), 32'd0);
    @(negedge clk);
    chk("add_start_after_pop", 32'(bus.alu_start), 32'd1);
    chk("add_level_after_pop", 32'(fifo_level), 32'd0);
    wait_rsp(1);
    chk("add_start_width", 32'(last_run), 32'd1);
    chk("add_alu_a_kept", 32'(bus.alu_a), 32'h05);
    chk("add_alu_b_kept", 32'(bus.alu_b), 32'h03);

    // mul FF*FF, done after 3 cycles
    @(posedge clk); #1;
    lat = 3;
    push(8'hFF, 8'hFF, 3'b100);
    wait_rsp(2);
    chk("mul_start_width", 32'(last_run), 32'd3);

    // Fill FIFO while response is stalled
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    lat = 1;
    push(8'h11, 8'h22, 3'b001);
    push(8'h0F, 8'h3C, 3'b010);
    push(8'hAA, 8'h55, 3'b011);
    push(8'h10, 8'h10, 3'b100);
    push(8'h77, 8'h88, 3'b101);
    bus.cmd_a = 8'hC8;
    bus.cmd_b = 8'h64;
    bus.cmd_op = 3'b001;
    bus.cmd_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("full_level", 32'(fifo_level), 32'd4);
      chk("full_cmd_ready", 32'(bus.cmd_ready), 32'd0);
      chk("stall_rsp_valid", 32'(bus.rsp_valid), 32'd1);
      chk("stall_rsp_result", 32'(bus.rsp_result), 32'h0033);
    end
    @(posedge clk); #1;
    bus.rsp_ready = 1'b1;
    push(8'hC8, 8'h64, 3'b001);
    wait_rsp(8);

    // xor with done never arriving
    @(posedge clk); #1;
    lat = 0;
    push(8'h0F, 8'hF0, 3'b011);
    wait_rsp(9);
    chk("to_start_width", 32'(last_run), 32'(TO));
`ifdef TINYALU_DRV_STATS_EN
    chk("stat_timeouts", 32'(stat_timeouts), 32'd1);
    chk("stat_ops", 32'(stat_ops), 32'(rsp_count));
`endif

    // rst_op
    @(posedge clk); #1;
    lat = 1;
    push(8'h12, 8'h34, 3'b111);
    wait_rsp(10);
    chk("rstop_low_width", 32'(last_rlow), 32'd2);
    chk("rstop_start_while_low", 32'(start_in_rst), 32'd0);

    // Reset in the middle of a mul
    @(posedge clk); #1;
    lat = 0;
    push(8'h03, 8'h04, 3'b100);
    @(negedge clk);
    @(negedge clk);
    chk("midrst_busy", 32'(bus.alu_start), 32'd1);
    #2 reset_n = 1'b0;
    void'(exp_q.pop_back());
    #1;
    chk("midrst_alu_start",   32'(bus.alu_start),   32'd0);
    chk("midrst_alu_a",       32'(bus.alu_a),       32'd0);
    chk("midrst_alu_op",      32'(bus.alu_op),      32'd0);
    chk("midrst_alu_reset_n", 32'(bus.alu_reset_n), 32'd0);
    chk("midrst_fifo_level",  32'(fifo_level),      32'd0);
    chk("midrst_rsp_valid",   32'(bus.rsp_valid),   32'd0);
    chk("midrst_rsp_result",  32'(bus.rsp_result),  32'd0);
`ifdef TINYALU_DRV_STATS_EN
    chk("midrst_stat_ops", 32'(stat_ops), 32'd0);
`endif
    @(posedge clk); #1 reset_n = 1'b1;
    @(negedge clk);
    chk("midrel_alu_reset_n_low", 32'(bus.alu_reset_n), 32'd0);
    @(negedge clk);
    chk("midrel_alu_reset_n_high", 32'(bus.alu_reset_n), 32'd1);
    vcnt = 0;
    repeat (30) begin
      @(negedge clk);
      if (bus.rsp_valid) vcnt++;
    end
    chk("midrel_no_rsp", 32'(vcnt), 32'd0);

    chk("sb_empty", 32'(exp_q.size()), 32'd0);
    chk("rsp_total", 32'(rsp_count), 32'd10);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/tinyalu_cmd_driver.md
Name: tinyalu_cmd_driver

Overview:
Synthesizable command stage that sits directly upstream of the TinyALU DUT.
- Accepts ALU commands on a valid/ready stream and buffers them in a small FIFO.
- Drives the ALU pin protocol (A, B, op, start, reset_n) and waits for done.
- Returns each result on a valid/ready response stream.
- Replaces hand-driven pin stimulus when TinyALU is embedded in a larger system.

Parameters:
FIFO_DEPTH, 4, command FIFO entries; power of 2, >=2
TIMEOUT, 16, max cycles alu_start stays high waiting for alu_done (>=4)

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
cmd_valid  in  1  command offered
cmd_ready  out  1  FIFO not full
cmd_a  in  8  operand A
cmd_b  in  8  operand B
cmd_op  in  3  opcode: no_op=000 add=001 and=010 xor=011 mul=100 rst_op=111
alu_a  out  8  to ALU A
alu_b  out  8  to ALU B
alu_op  out  3  to ALU op
alu_start  out  1  to ALU start
alu_reset_n  out  1  to ALU reset_n
alu_done  in  1  from ALU done
alu_result  in  16  from ALU result
rsp_valid  out  1  response available
rsp_ready  in  1  response accepted
rsp_result  out  16  ALU result
rsp_op  out  3  opcode of completed command
rsp_timeout  out  1  command aborted on timeout
fifo_level  out  $clog2(FIFO_DEPTH+1)  FIFO occupancy

Behaviour:
Reset values
- Async reset clears the FIFO and all outputs to 0; FSM goes to IDLE.
- alu_reset_n is 0 during reset and registers to 1 on the first clk edge after release.
- Reset mid-operation aborts the command with no response.

FIFO
- cmd_ready = (fifo_level != FIFO_DEPTH); push on cmd_valid & cmd_ready.
- Push and pop in the same cycle leave fifo_level unchanged.
- Pointers wrap modulo FIFO_DEPTH. Commands are issued strictly in order.

FSM states: IDLE, EXEC, NOP, RST, RESP; all outputs registered.
- IDLE: if FIFO non-empty, pop and load alu_a, alu_b, alu_op, rsp_op. Then:
  - add/and/xor/mul -> EXEC; set alu_start=1 and clear the timeout counter.
  - no_op and illegal codes 101/110 -> NOP; set alu_start=1.
  - rst_op -> RST; set alu_reset_n=0, alu_start=0.
  - First pop occurs on the edge after a push into an empty FIFO.
- EXEC: alu_start held high.
  - alu_done sampled 1: capture rsp_result=alu_result, alu_start<=0, rsp_timeout<=0, go RESP.
  - Counter reaches TIMEOUT with no done: alu_start<=0, rsp_result<=16'hFFFF, rsp_timeout<=1, go RESP.
  - alu_start is therefore high for exactly TIMEOUT cycles in the timeout case.
- NOP: alu_start high exactly one cycle; rsp_result<=0; go RESP.
- RST: alu_reset_n low exactly 2 cycles, then 1; rsp_result<=0; go RESP.
- RESP: rsp_valid=1, payload stable until rsp_ready; on handshake rsp_valid<=0 and go IDLE.
  - No back-to-back bypass: a 1-cycle IDLE always separates responses.
- alu_a, alu_b, alu_op retain last values between commands.
- alu_done outside EXEC is ignored.
- cmd pushes continue while FSM is busy or stalled in RESP.

Optional Feature:
TINYALU_DRV_STATS_EN
- Defined: adds output ports stat_ops[15:0], counting completed response handshakes, and stat_timeouts[7:0], counting timeouts.
- Both counters saturate and clear on reset.
- Undefined: ports and logic are absent; all other behaviour is identical.

Test Plan:
- add A=8'h05 B=8'h03, ALU model raises done 1 cycle after start -> rsp_result=16'h0008, rsp_op=001, rsp_timeout=0; alu_start drops the edge after done.
- mul A=8'hFF B=8'hFF, done after 3 cycles -> rsp_result=16'hFE01; alu_start high 3 cycles.
- 6 back-to-back pushes with rsp_ready=0 (FIFO_DEPTH=4) -> fifo_level reaches 4, cmd_ready=0, 6th push stalls; with rsp_ready=1 the 6 responses arrive in push order.
- xor with alu_done stuck 0, TIMEOUT=16 -> alu_start high exactly 16 cycles, rsp_result=16'hFFFF, rsp_timeout=1; with macro defined, stat_timeouts=1.
- rst_op -> alu_reset_n low exactly 2 cycles, alu_start=0, then response with rsp_result=16'h0000, rsp_op=111.
- reset_n pulsed low mid-mul -> outputs 0 immediately, fifo_level=0, no rsp_valid after release, alu_reset_n=1 one edge after release.
